// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit: forward-select encodings,
// mul/div tracker state type and the forward-priority helper.
package hazard_pkg;

   // Operand source selects for the execute-stage ALU muxes.
   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   typedef enum logic {
      StIdle,
      StBusy
   } mdState_t;

   // M-stage result is younger than W-stage, so it wins when both match.
   function automatic logic [1:0] fwdSelect(input logic mHit, input logic wHit);
      if (mHit) begin
         return FWD_M;
      end else if (wHit) begin
         return FWD_W;
      end
      return FWD_RF;
   endfunction

endpackage

// File: rtl/muldiv_tracker.sv
// Tracks an in-flight multiply/divide. busy is high for MULDIV_LATENCY-1
// cycles after the start cycle; a start while busy restarts the count.
// MULDIV_LATENCY is legal in 2..15 (4-bit down-counter).
module muldiv_tracker
   import hazard_pkg::*;
#(
   parameter int unsigned MULDIV_LATENCY = 4
) (
   input  logic clock,
   input  logic reset_n,
   input  logic start,
   output logic busy
);

   localparam logic [3:0] Reload = 4'(MULDIV_LATENCY - 1);

   mdState_t   stateQ;
   logic [3:0] countQ;

   // Single-block FSM with registered busy flag and synchronous reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         stateQ <= StIdle;
         countQ <= 4'd0;
         busy   <= 1'b0;
      end else begin
         unique case (stateQ)
            StIdle: begin
               if (start) begin
                  stateQ <= StBusy;
                  countQ <= Reload;
                  busy   <= 1'b1;
               end
            end
            StBusy: begin
               if (start) begin
                  // New op supersedes the one in flight.
                  countQ <= Reload;
               end else if (countQ == 4'd1) begin
                  stateQ <= StIdle;
                  countQ <= 4'd0;
                  busy   <= 1'b0;
               end else begin
                  countQ <= countQ - 4'd1;
               end
            end
            default: begin
               stateQ <= StIdle;
               countQ <= 4'd0;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard unit: operand forwarding, load-use / branch / mul-div
// stalls and a saturating stall-cycle counter.
// Optional mul/div interlock enabled by defining HAZARD_MULDIV_EN.
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int unsigned REG_ID_W       = 5,
   parameter int unsigned MULDIV_LATENCY = 4,
   parameter int unsigned STALL_CNT_W    = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [REG_ID_W-1:0]    RsD,
   input  logic [REG_ID_W-1:0]    RtD,
   input  logic [REG_ID_W-1:0]    RsE,
   input  logic [REG_ID_W-1:0]    RtE,
   input  logic [REG_ID_W-1:0]    WriteRegE,
   input  logic [REG_ID_W-1:0]    WriteRegM,
   input  logic [REG_ID_W-1:0]    WriteRegW,
   input  logic                   BranchD,
   input  logic                   RegWriteE,
   input  logic                   MemtoRegE,
   input  logic                   RegWriteM,
   input  logic                   MemtoRegM,
   input  logic                   RegWriteW,
   input  logic                   MulDivStartE,
   input  logic                   MulDivUseD,
   output logic                   StallF,
   output logic                   StallD,
   output logic                   FlushE,
   output logic                   ForwardAD,
   output logic                   ForwardBD,
   output logic [1:0]             ForwardAE,
   output logic [1:0]             ForwardBE,
   output logic                   MulDivBusy,
   output logic [STALL_CNT_W-1:0] StallCount
);

   logic mValid, wValid, eValid;
   logic lwStall, brStall, mdStall, anyStall;

`ifdef HAZARD_MULDIV_EN
   muldiv_tracker #(
      .MULDIV_LATENCY(MULDIV_LATENCY)
   ) uMulDivTracker (
      .clock  (clock),
      .reset_n(reset_n),
      .start  (MulDivStartE),
      .busy   (MulDivBusy)
   );
   assign mdStall = MulDivUseD & MulDivBusy;
`else
   logic unusedMulDiv;
   assign unusedMulDiv = MulDivStartE ^ MulDivUseD;
   assign MulDivBusy   = 1'b0;
   assign mdStall      = 1'b0;
`endif

   // Forwarding selects and stall conditions; register 0 never matches.
   always_comb begin
      mValid = RegWriteM && (WriteRegM != '0);
      wValid = RegWriteW && (WriteRegW != '0);
      eValid = RegWriteE && (WriteRegE != '0);

      ForwardAE = fwdSelect(mValid && (WriteRegM == RsE), wValid && (WriteRegW == RsE));
      ForwardBE = fwdSelect(mValid && (WriteRegM == RtE), wValid && (WriteRegW == RtE));
      ForwardAD = mValid && (WriteRegM == RsD);
      ForwardBD = mValid && (WriteRegM == RtD);

      lwStall = MemtoRegE && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));
      brStall = BranchD &&
                ((eValid && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                 (MemtoRegM && (WriteRegM != '0) && ((WriteRegM == RsD) || (WriteRegM == RtD))));

      anyStall = lwStall | brStall | mdStall;
      StallF   = anyStall;
      StallD   = anyStall;
      FlushE   = anyStall;
   end

   // Saturating count of decode-stall cycles.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         StallCount <= '0;
      end else if (StallD && (StallCount != '1)) begin
         StallCount <= StallCount + 1'b1;
      end
   end

endmodule
